// File: rtl/cpri_rx_rd_sched.sv
// cpri_rx_rd_sched: lock-step read scheduler for per-lane CPRI RX page buffers.
// Waits for every enabled lane to hold a full page, then reads one BURST_LEN-beat
// burst from all of them together, paced by downstream ready.
// Optional feature macro: RD_SCHED_STATS_EN (BURST stall-cycle counter on o_stall_cnt).
module cpri_rx_rd_sched #(
    parameter int unsigned NUM_LANE    = 8,
    parameter int unsigned BURST_LEN   = 3168,
    parameter int unsigned GAP_CYC     = 16,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NUM_LANE-1:0] i_lane_mask,
    input  logic [NUM_LANE-1:0] i_lane_vld,
    input  logic                i_ds_ready,
    output logic [NUM_LANE-1:0] o_rd_en,
    output logic                o_burst_sop,
    output logic                o_burst_eop,
    output logic [CNT_W-1:0]    o_burst_cnt,
    output logic [2:0]          o_state,
    output logic                o_timeout,
    output logic [NUM_LANE-1:0] o_late_mask,
    output logic [31:0]         o_stall_cnt
);

    // Terminal values; degenerate parameter values collapse to a one-cycle phase.
    localparam int unsigned BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BEAT_LST = (BURST_LEN > 1) ? BURST_LEN - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned GAP_LST  = (GAP_CYC > 1) ? GAP_CYC - 1 : 0;
    localparam int unsigned TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TMR_LST  = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BURST = 3'd2,
        ST_GAP   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [TMR_W-1:0]    tmr;
    logic [NUM_LANE-1:0] lane_mask_q;

    logic all_rdy;
    logic in_burst;
    logic beat_go;
    logic beat_last;

    // Ready when at least one lane is enabled and every enabled lane has a page.
    assign all_rdy   = (|i_lane_mask) & (&(i_lane_vld | ~i_lane_mask));
    assign in_burst  = (state == ST_BURST);
    assign beat_go   = in_burst & i_ds_ready;
    assign beat_last = (beat_cnt == BEAT_W'(BEAT_LST));

    // Read strobes follow downstream ready with zero latency so no beat is lost.
    assign o_rd_en     = in_burst ? (lane_mask_q & {NUM_LANE{i_ds_ready}}) : '0;
    assign o_burst_sop = beat_go & (beat_cnt == '0);
    assign o_burst_eop = beat_go & beat_last;
    assign o_state     = 3'(state);

    // Scheduler FSM with its phase counters and status registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            tmr         <= '0;
            lane_mask_q <= '0;
            o_burst_cnt <= '0;
            o_timeout   <= 1'b0;
            o_late_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_enable) begin
                        state <= ST_WAIT;
                        tmr   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!i_enable) begin
                        state <= ST_IDLE;
                        tmr   <= '0;
                    end else if (all_rdy) begin
                        state       <= ST_BURST;
                        lane_mask_q <= i_lane_mask;
                        beat_cnt    <= '0;
                        tmr         <= '0;
                    end else if (tmr == TMR_W'(TMR_LST)) begin
                        state       <= ST_ERR;
                        o_timeout   <= 1'b1;
                        o_late_mask <= i_lane_mask & ~i_lane_vld;
                        tmr         <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_BURST: begin
                    // Burst always runs to completion so buffer page addressing stays aligned.
                    if (i_ds_ready) begin
                        if (beat_last) begin
                            beat_cnt    <= '0;
                            o_burst_cnt <= o_burst_cnt + CNT_W'(1);
                            gap_cnt     <= '0;
                            state       <= ST_GAP;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LST)) begin
                        gap_cnt <= '0;
                        state   <= i_enable ? ST_WAIT : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_ERR: begin
                    if (!i_enable) begin
                        state       <= ST_IDLE;
                        o_timeout   <= 1'b0;
                        o_late_mask <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RD_SCHED_STATS_EN
    // Saturating count of BURST cycles stalled by downstream backpressure.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_cnt <= '0;
        end else if (in_burst && !i_ds_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cpri_rx_rd_sched.sv
// Self-checking bench for cpri_rx_rd_sched: directed scenarios plus random traffic,
// every cycle compared against a behavioural scheduler model.
module tb_cpri_rx_rd_sched;

    localparam int unsigned NL  = 4;
    localparam int unsigned BL  = 8;
    localparam int unsigned GAP = 2;
    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 2;

    localparam int S_IDLE = 0, S_WAIT = 1, S_BURST = 2, S_GAP = 3, S_ERR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NL-1:0] mask;
    logic [NL-1:0] vld;
    logic          ds;
    logic [NL-1:0] rd_en;
    logic          sop;
    logic          eop;
    logic [CW-1:0] bcnt;
    logic [2:0]    st;
    logic          tout;
    logic [NL-1:0] late;
    logic [31:0]   stall;

    cpri_rx_rd_sched #(
        .NUM_LANE(NL), .BURST_LEN(BL), .GAP_CYC(GAP), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_lane_mask(mask),
        .i_lane_vld(vld), .i_ds_ready(ds), .o_rd_en(rd_en), .o_burst_sop(sop),
        .o_burst_eop(eop), .o_burst_cnt(bcnt), .o_state(st), .o_timeout(tout),
        .o_late_mask(late), .o_stall_cnt(stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: phase, beats already issued, gap/wait cycles spent, status.
    int            m_state;
    int            m_beats;
    int            m_gap;
    int            m_wait;
    logic [NL-1:0] m_mask;
    int            m_bursts;
    logic          m_to;
    logic [NL-1:0] m_late;
    logic [31:0]   m_stall;

    // Most recent observation, for directed checks.
    logic [NL-1:0] obs_rd;
    logic          obs_sop, obs_eop, obs_to;
    logic [CW-1:0] obs_cnt;
    logic [2:0]    obs_st;
    logic [NL-1:0] obs_late;
    logic [31:0]   obs_stall;
    int            n_beats, n_sop, n_eop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_beats = 0; m_gap = 0; m_wait = 0; m_mask = '0;
        m_bursts = 0; m_to = 1'b0; m_late = '0; m_stall = '0;
    endtask

    // One clock: compare at the falling edge, advance the model, return after the rising edge.
    task automatic tick();
        logic [NL-1:0] w_rd;
        logic          issue;
        logic          rdy;
        @(negedge clk);
        obs_rd = rd_en; obs_sop = sop; obs_eop = eop; obs_cnt = bcnt; obs_st = st;
        obs_to = tout; obs_late = late; obs_stall = stall;
        if (rd_en != '0) n_beats++;
        if (sop) n_sop++;
        if (eop) n_eop++;

        issue = (m_state == S_BURST) && ds;
        w_rd  = issue ? m_mask : '0;
        check("rd_en",   32'(rd_en), 32'(w_rd));
        check("sop",     32'(sop),   32'(issue && m_beats == 0));
        check("eop",     32'(eop),   32'(issue && m_beats == BL - 1));
        check("state",   32'(st),    32'(m_state));
        check("bcnt",    32'(bcnt),  32'(m_bursts % (1 << CW)));
        check("timeout", 32'(tout),  32'(m_to));
        check("late",    32'(late),  32'(m_late));
`ifdef RD_SCHED_STATS_EN
        check("stall",   stall,      m_stall);
`else
        check("stall",   stall,      32'd0);
`endif

        if (rst) begin
            model_reset();
        end else begin
            rdy = (mask != '0) && ((vld | ~mask) == {NL{1'b1}});
            case (m_state)
                S_IDLE: if (en) begin m_state = S_WAIT; m_wait = 0; end
                S_WAIT: begin
                    if (!en) begin
                        m_state = S_IDLE;
                    end else if (rdy) begin
                        m_state = S_BURST; m_mask = mask; m_beats = 0;
                    end else if (m_wait + 1 == TO) begin
                        m_state = S_ERR; m_to = 1'b1; m_late = mask & ~vld;
                    end else begin
                        m_wait++;
                    end
                end
                S_BURST: begin
                    if (!ds) begin
                        if (m_stall != 32'hFFFF_FFFF) m_stall++;
                    end else begin
                        m_beats++;
                        if (m_beats == BL) begin
                            m_bursts++; m_state = S_GAP; m_gap = 0;
                        end
                    end
                end
                S_GAP: begin
                    m_gap++;
                    if (m_gap >= GAP || GAP == 0) begin
                        m_state = en ? S_WAIT : S_IDLE; m_wait = 0;
                    end
                end
                S_ERR: if (!en) begin m_state = S_IDLE; m_to = 1'b0; m_late = '0; end
                default: m_state = S_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        n_beats = 0; n_sop = 0; n_eop = 0;
    endtask

    int seq[5] = '{1, 2, 3, 0, 1};
    bit hold_bad;

    initial begin
        rst = 1'b1; en = 1'b0; mask = '0; vld = '0; ds = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        clr_stats();

        // Reset state with reset still asserted.
        tick();
        check("rst_state", 32'(obs_st), 32'd0);
        check("rst_cnt",   32'(obs_cnt), 32'd0);
        rst = 1'b0;

        // Full-mask burst with no backpressure.
        en = 1'b1; mask = 4'hF; vld = 4'hF; ds = 1'b1;
        clr_stats();
        repeat (10) tick();
        vld = 4'h0;
        repeat (2) tick();
        tick();
        check("t1_beats", 32'(n_beats), 32'd8);
        check("t1_sop",   32'(n_sop),   32'd1);
        check("t1_eop",   32'(n_eop),   32'd1);
        check("t1_state", 32'(obs_st),  32'd1);
        check("t1_cnt",   32'(obs_cnt), 32'd1);

        // Alternating downstream ready: 8 beats over 15 cycles.
        vld = 4'hF;
        tick();
        clr_stats();
        for (int i = 0; i < 15; i++) begin
            ds = (i % 2 == 0);
            tick();
        end
        check("t2_beats", 32'(n_beats), 32'd8);
        check("t2_eop",   32'(n_eop),   32'd1);
`ifdef RD_SCHED_STATS_EN
        check("t2_stall", obs_stall, 32'd7);
`else
        check("t2_stall", obs_stall, 32'd0);
`endif

        // Partial mask; mask/valid changes inside the burst are ignored.
        ds = 1'b1; vld = 4'h0;
        repeat (2) tick();
        mask = 4'h5; vld = 4'h5;
        tick();
        mask = 4'hF; vld = 4'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t3_rd", 32'(obs_rd), 32'h5);
        end

        // Lane 2 never valid: timeout after 16 WAIT cycles.
        mask = 4'hF; vld = 4'hB;
        repeat (2 + 16) tick();
        tick();
        check("t4_state", 32'(obs_st),   32'd4);
        check("t4_to",    32'(obs_to),   32'd1);
        check("t4_late",  32'(obs_late), 32'h4);
        en = 1'b0;
        tick();
        tick();
        check("t4_idle",   32'(obs_st),   32'd0);
        check("t4_to_clr", 32'(obs_to),   32'd0);
        check("t4_late0",  32'(obs_late), 32'd0);

        // Enable dropped mid-burst: burst completes, then IDLE.
        en = 1'b1; vld = 4'hF; ds = 1'b1;
        repeat (2) tick();
        clr_stats();
        repeat (3) tick();
        en = 1'b0;
        repeat (5) tick();
        check("t5_beats", 32'(n_beats), 32'd8);
        check("t5_eop",   32'(n_eop),   32'd1);
        repeat (2) tick();
        tick();
        check("t5_idle", 32'(obs_st), 32'd0);

        // Reset at beat 5 aborts the burst.
        en = 1'b1;
        repeat (2) tick();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t5_rst_state", 32'(obs_st),  32'd0);
        check("t5_rst_rd",    32'(obs_rd),  32'd0);
        check("t5_rst_cnt",   32'(obs_cnt), 32'd0);
        check("t5_rst_to",    32'(obs_to),  32'd0);

        // Burst counter wraps with a 2-bit width.
        for (int b = 0; b < 5; b++) begin
            bit got;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                tick();
                got = obs_eop;
            end
            if (!got) check("t6_eop_budget", 32'd0, 32'd1);
            tick();
            check("t6_cnt", 32'(obs_cnt), 32'(seq[b]));
        end

        // Random traffic against the model.
        hold_bad = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 40 == 0) hold_bad = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 7) == 0) mask = NL'($urandom_range(0, 15));
            if (hold_bad)
                vld = mask & ~NL'(1 << $urandom_range(0, NL - 1));
            else if ($urandom_range(0, 9) < 7)
                vld = 4'hF;
            else
                vld = NL'($urandom_range(0, 15));
            ds = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
